// File: rtl/switch_debounce_2ch_pkg.sv
// rtl/switch_debounce_2ch_pkg.sv - shared state encoding and debounce length defaults
package switch_debounce_2ch_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } deb_state_t;

    localparam int STABLE_CYCLES_BOARD = 500000;
    localparam int STABLE_CYCLES_SIM   = 4;

endpackage

// File: rtl/switch_debounce_2ch_debounce_ch.sv
// rtl/switch_debounce_2ch_debounce_ch.sv - one channel: 2-flop synchroniser, debounce FSM, edge strobes
module debounce_ch
    import switch_debounce_2ch_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_BOARD,
    parameter int CNT_W         = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic out,
    output logic rise,
    output logic fall,
    output logic strobe_next
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1;
    logic             s;
    deb_state_t       state;
    deb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             out_next;
    logic             rise_next;
    logic             fall_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            state <= ST_IDLE;
            cnt   <= '0;
            out   <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
            state <= state_next;
            cnt   <= cnt_next;
            out   <= out_next;
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end

    // Any sample agreeing with out throws away the whole run: no partial credit.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        out_next   = out;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s != out) begin
                    state_next = ST_COUNT;
                    cnt_next   = CNT_W'(1);
                end
            end
            ST_COUNT: begin
                if (s == out) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    out_next   = s;
                    rise_next  = s;
                    fall_next  = ~s;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    assign strobe_next = rise_next | fall_next;

endmodule

// File: rtl/switch_debounce_2ch.sv
// rtl/switch_debounce_2ch.sv - two independent debounced switch channels with edge strobes
module switch_debounce_2ch
    import switch_debounce_2ch_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_BOARD,
    parameter int CNT_W         = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_a_raw,
    input  logic sw_b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic changed
);

    logic strobe_next_a;
    logic strobe_next_b;

    debounce_ch #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_ch_a (
        .clk         (clk),
        .rst         (rst),
        .raw         (sw_a_raw),
        .out         (a),
        .rise        (a_rise),
        .fall        (a_fall),
        .strobe_next (strobe_next_a)
    );

    debounce_ch #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_ch_b (
        .clk         (clk),
        .rst         (rst),
        .raw         (sw_b_raw),
        .out         (b),
        .rise        (b_rise),
        .fall        (b_fall),
        .strobe_next (strobe_next_b)
    );

    // Built from the strobes' next values so changed lands in the same cycle as them.
    always_ff @(posedge clk) begin
        if (rst) begin
            changed <= 1'b0;
        end else begin
            changed <= strobe_next_a | strobe_next_b;
        end
    end

endmodule

// File: tb/tb_switch_debounce_2ch.sv
// tb/tb_switch_debounce_2ch.sv - randomized and directed bench for switch_debounce_2ch
module tb_switch_debounce_2ch;

    localparam int S = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw_a_raw = 1'b0;
    logic sw_b_raw = 1'b0;
    logic a, b, a_rise, a_fall, b_rise, b_fall, changed;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    switch_debounce_2ch #(
        .STABLE_CYCLES (S),
        .CNT_W         (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_a_raw (sw_a_raw),
        .sw_b_raw (sw_b_raw),
        .a        (a),
        .b        (b),
        .a_rise   (a_rise),
        .a_fall   (a_fall),
        .b_rise   (b_rise),
        .b_fall   (b_fall),
        .changed  (changed)
    );

    always #5 clk = ~clk;

    // Model: per channel, the last S synchronised samples seen since the last flip/reset.
    bit m_s1   [2];
    bit m_s2   [2];
    bit m_out  [2];
    bit m_rise [2];
    bit m_fall [2];
    bit m_hist [2][S];
    int m_nsamp[2];
    bit m_changed;

    always @(posedge clk) begin
        bit raw_v[2];
        raw_v[0] = sw_a_raw;
        raw_v[1] = sw_b_raw;
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                m_s1[c] = 0; m_s2[c] = 0; m_out[c] = 0;
                m_rise[c] = 0; m_fall[c] = 0; m_nsamp[c] = 0;
            end else begin
                bit s_used;
                bit all_diff;
                s_used   = m_s2[c];
                m_s2[c]  = m_s1[c];
                m_s1[c]  = raw_v[c];
                m_rise[c] = 0;
                m_fall[c] = 0;
                for (int i = S - 1; i > 0; i--) m_hist[c][i] = m_hist[c][i-1];
                m_hist[c][0] = s_used;
                if (m_nsamp[c] < S) m_nsamp[c]++;
                all_diff = 1;
                for (int i = 0; i < S; i++) if (m_hist[c][i] == m_out[c]) all_diff = 0;
                if (m_nsamp[c] >= S && all_diff) begin
                    m_out[c]   = ~m_out[c];
                    m_rise[c]  = m_out[c];
                    m_fall[c]  = ~m_out[c];
                    m_nsamp[c] = 0;
                end
            end
        end
        m_changed = !rst && (m_rise[0] | m_fall[0] | m_rise[1] | m_fall[1]);
        cmp_en = 1'b1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [6:0] act, exp;
            act = {a, b, a_rise, a_fall, b_rise, b_fall, changed};
            exp = {m_out[0], m_out[1], m_rise[0], m_fall[0], m_rise[1], m_fall[1], m_changed};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL model_cmp t=%0t actual={a,b,ar,af,br,bf,chg}=%b expected=%b", $time, act, exp);
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        int strobes;
        int hold_a, hold_b;

        // 1: reset with raw A held high
        rst = 1'b1; sw_a_raw = 1'b1; sw_b_raw = 1'b0;
        step(3);
        chk("t1_rst_a", a, 1'b0);
        chk("t1_rst_arise", a_rise, 1'b0);
        chk("t1_rst_chg", changed, 1'b0);
        rst = 1'b0;
        step(5);
        chk("t1_a_e4", a, 1'b0);
        step(1);
        chk("t1_a_e5", a, 1'b1);
        chk("t1_arise_e5", a_rise, 1'b1);
        chk("t1_chg_e5", changed, 1'b1);
        step(1);
        chk("t1_arise_e6", a_rise, 1'b0);
        chk("t1_chg_e6", changed, 1'b0);

        // 4: release
        sw_a_raw = 1'b0;
        step(5);
        chk("t4_a_e4", a, 1'b1);
        step(1);
        chk("t4_a_e5", a, 1'b0);
        chk("t4_afall_e5", a_fall, 1'b1);
        chk("t4_arise_e5", a_rise, 1'b0);
        step(2);

        // 2: clean press
        sw_a_raw = 1'b1;
        step(5);
        chk("t2_a_e4", a, 1'b0);
        step(1);
        chk("t2_a_e5", a, 1'b1);
        chk("t2_arise_e5", a_rise, 1'b1);
        chk("t2_afall_e5", a_fall, 1'b0);
        sw_a_raw = 1'b0;
        step(8);

        // 3: bounce rejection, then hold
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            sw_a_raw = (i % 4 != 3);
            step(1);
            strobes += a_rise + a_fall + changed;
        end
        chk("t3_a_bounce", a, 1'b0);
        checks++;
        if (strobes != 0) begin
            failures++;
            $display("FAIL t3_strobes actual=%0d expected=0", strobes);
        end
        sw_a_raw = 1'b1;
        step(5);
        chk("t3_a_e4", a, 1'b0);
        step(1);
        chk("t3_a_e5", a, 1'b1);
        sw_a_raw = 1'b0;
        step(8);

        // 5: simultaneous channels
        sw_a_raw = 1'b1; sw_b_raw = 1'b1;
        step(6);
        chk("t5_arise", a_rise, 1'b1);
        chk("t5_brise", b_rise, 1'b1);
        chk("t5_chg", changed, 1'b1);
        step(1);
        chk("t5_chg_next", changed, 1'b0);
        sw_a_raw = 1'b0; sw_b_raw = 1'b0;
        step(8);

        // 6: reset mid-count
        sw_a_raw = 1'b1;
        step(3);
        rst = 1'b1;
        step(1);
        chk("t6_a_rst", a, 1'b0);
        rst = 1'b0;
        step(5);
        chk("t6_a_e4", a, 1'b0);
        step(1);
        chk("t6_a_e5", a, 1'b1);
        chk("t6_arise_e5", a_rise, 1'b1);

        // Randomized levels with random hold lengths and sporadic resets
        hold_a = 0; hold_b = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_a == 0) begin
                sw_a_raw = 1'($urandom_range(0, 1));
                hold_a = $urandom_range(1, 8);
            end
            if (hold_b == 0) begin
                sw_b_raw = 1'($urandom_range(0, 1));
                hold_b = $urandom_range(1, 8);
            end
            hold_a--; hold_b--;
            rst = ($urandom_range(0, 399) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
